// File: rtl/tdm_dmux_rx.sv
// tdm_dmux_rx: serial TDM receiver / channel demultiplexer.
// Hunts for the frame-sync strobe, tracks frame alignment with a flywheel
// that tolerates MISS_LIMIT-1 consecutive missing syncs, and deserialises
// each MSB-first slot into its channel slice of ch_data.
// Optional feature, macro TDM_RX_PARITY_EN: each slot carries one extra
// trailing even-parity bit; mismatches are reported on parity_err.
//
// Handshake: there is no back-pressure. A bit is consumed on every clock
// with enable=1. ch_valid[k] is a one-cycle strobe meaning "slice k of
// ch_data was just reloaded"; the consumer must take it on that cycle.
// frame_done, sync_err and parity_err are one-cycle strobes; sync_lock is
// a level.
module tdm_dmux_rx #(
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 8,
  parameter int MISS_LIMIT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       sd_in,
  input  logic                       fs_in,
  output logic [NUM_CH*CH_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]          ch_valid,
  output logic                       frame_done,
  output logic                       sync_lock,
  output logic                       sync_err,
  output logic [NUM_CH-1:0]          parity_err
);

`ifdef TDM_RX_PARITY_EN
  localparam int SLOT = CH_WIDTH + 1;
  // Parity mode keeps all data bits; the parity bit itself is never stored.
  localparam int SHW  = CH_WIDTH;
`else
  localparam int SLOT = CH_WIDTH;
  // The final data bit comes straight from sd_in, so one bit fewer is kept.
  localparam int SHW  = CH_WIDTH - 1;
`endif
  localparam int BW = $clog2(SLOT);
  localparam int CW = $clog2(NUM_CH);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(SLOT - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  // Current FSM state, kept as a named signal for checkers to bind to.
  state_e                     state_q, state_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]              ch_cnt_q, ch_cnt_d;
  logic [MW-1:0]              miss_cnt_q, miss_cnt_d;
  logic [SHW-1:0]             shift_q, shift_d;

  logic [NUM_CH*CH_WIDTH-1:0] ch_data_d;
  logic [NUM_CH-1:0]          ch_valid_d;
  logic                       frame_done_d;
  logic                       sync_lock_d;
  logic                       sync_err_d;

  logic [CH_WIDTH-1:0]        word;
  logic [MW-1:0]              miss_inc;
  logic                       at_boundary;
  logic                       take_bit;

`ifdef TDM_RX_PARITY_EN
  logic [NUM_CH-1:0]          parity_err_q, parity_err_d;
  logic                       perr;
`endif

  // State register and all registered outputs; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      miss_cnt_q   <= '0;
      shift_q      <= '0;
      ch_data      <= '0;
      ch_valid     <= '0;
      frame_done   <= 1'b0;
      sync_lock    <= 1'b0;
      sync_err     <= 1'b0;
`ifdef TDM_RX_PARITY_EN
      parity_err_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      shift_q      <= shift_d;
      ch_data      <= ch_data_d;
      ch_valid     <= ch_valid_d;
      frame_done   <= frame_done_d;
      sync_lock    <= sync_lock_d;
      sync_err     <= sync_err_d;
`ifdef TDM_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

`ifdef TDM_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = '0;
`endif

  // Next-state logic: alignment tracking, bit shifting and slot completion.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    shift_d      = shift_q;
    ch_data_d    = ch_data;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_lock_d  = sync_lock;
    sync_err_d   = 1'b0;
    take_bit     = 1'b0;
    at_boundary  = (bit_cnt_q == '0) && (ch_cnt_q == '0);
    miss_inc     = miss_cnt_q + MW'(1);
`ifdef TDM_RX_PARITY_EN
    parity_err_d = '0;
    word         = shift_q;
    perr         = ^{shift_q, sd_in};
`else
    word         = {shift_q, sd_in};
`endif

    if (enable) begin
      case (state_q)
        HUNT: begin
          if (fs_in) begin
            state_d    = RECV;
            ch_cnt_d   = '0;
            miss_cnt_d = '0;
            bit_cnt_d  = BW'(1);
            take_bit   = 1'b1;
          end
        end
        RECV: begin
          if (at_boundary) begin
            if (fs_in) begin
              miss_cnt_d  = '0;
              sync_lock_d = 1'b1;
              bit_cnt_d   = BW'(1);
              take_bit    = 1'b1;
            end else if (miss_inc == MISS_MAX) begin
              // Too many missing syncs: drop lock and discard this bit.
              state_d     = HUNT;
              miss_cnt_d  = MISS_MAX;
              sync_lock_d = 1'b0;
            end else begin
              // Flywheel: assume the frame started here anyway.
              miss_cnt_d = miss_inc;
              bit_cnt_d  = BW'(1);
              take_bit   = 1'b1;
            end
          end else if (fs_in) begin
            // Misplaced sync: abandon the partial slot and restart the frame.
            sync_err_d  = 1'b1;
            sync_lock_d = 1'b0;
            ch_cnt_d    = '0;
            miss_cnt_d  = '0;
            bit_cnt_d   = BW'(1);
            take_bit    = 1'b1;
          end else begin
            take_bit = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              for (int k = 0; k < NUM_CH; k++) begin
                if (ch_cnt_q == CW'(k)) begin
                  ch_data_d[k*CH_WIDTH +: CH_WIDTH] = word;
                  ch_valid_d[k] = 1'b1;
`ifdef TDM_RX_PARITY_EN
                  parity_err_d[k] = perr;
`endif
                end
              end
              if (ch_cnt_q == LAST_CH) begin
                ch_cnt_d     = '0;
                frame_done_d = 1'b1;
              end else begin
                ch_cnt_d = ch_cnt_q + CW'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (take_bit) begin
      shift_d = SHW'({shift_q, sd_in});
    end
  end

endmodule
